// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB slave terminating the team's APB master. Holds a register file of
//   `depth` words, inserts `wait_cycles` wait states in the access phase,
//   returns read data and flags out-of-range word addresses with PSLVERR.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous active-high reset
//   PSEL     : slave select
//   PEN      : enable, high in the access phase
//   PW       : 1 = write, 0 = read
//   PADDR    : word address, sampled in the access phase
//   PWDATA   : write data
//   PREADY   : transfer completes in this cycle
//   PRDATA   : read data, zero unless a non-error read completes
//   PSLVERR  : error response, qualified by PREADY
//   xfer_cnt : count of completed transfers, wraps at 16 bits
//
// Timing: the FSM enters SETUP on the edge after the master's setup cycle.
// Counting that SETUP-state cycle as T, PREADY rises in T+1+wait_cycles.
module apb_slave_regfile #(
  parameter int unsigned size        = 32,
  parameter int unsigned ad_size     = 8,
  parameter int unsigned depth       = 16,
  parameter int unsigned wait_cycles = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PSEL,
  input  logic               PEN,
  input  logic               PW,
  input  logic [ad_size-1:0] PADDR,
  input  logic [size-1:0]    PWDATA,
  output logic               PREADY,
  output logic [size-1:0]    PRDATA,
  output logic               PSLVERR,
  output logic [15:0]        xfer_cnt
);

  localparam int unsigned iw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [ad_size:0] depth_a = (ad_size + 1)'(depth);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [15:0]     cnt;
  logic [size-1:0] regs [depth];
  logic            addr_err;
  logic [iw-1:0]   idx;

  assign addr_err = {1'b0, PADDR} >= depth_a;
  assign idx      = PADDR[iw-1:0];

  // Outputs decode only registered state plus the bus control/address inputs.
  assign PREADY   = (state == ACCESS) & PSEL & PEN & (wait_cnt == 4'd0);
  assign PSLVERR  = PREADY & addr_err;
  assign PRDATA   = (PREADY & ~PW & ~addr_err) ? regs[idx] : '0;
  assign xfer_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      cnt      <= '0;
      for (int unsigned i = 0; i < depth; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // PSEL+PEN without a setup phase is ignored here.
          if (PSEL && !PEN) begin
            state    <= SETUP;
            wait_cnt <= 4'(wait_cycles);
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
          if (!PSEL || PREADY) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (PREADY) begin
        cnt <= cnt + 16'd1;
        if (PW && !addr_err) begin
          regs[idx] <= PWDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        psel;
  logic              pen;
  logic              pw;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic [2:0]        pready;
  logic [2:0]        pslverr;
  logic [2:0][31:0]  prdata;
  logic [2:0][15:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Index 0: wait_cycles=0, index 1: wait_cycles=1, index 2: wait_cycles=3.
  apb_slave_regfile #(.size(32), .ad_size(8), .depth(16), .wait_cycles(0)) u_w0 (
    .clk(clk), .rst(rst), .PSEL(psel[0]), .PEN(pen), .PW(pw), .PADDR(paddr),
    .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]),
    .PSLVERR(pslverr[0]), .xfer_cnt(cnt[0])
  );

  apb_slave_regfile #(.size(32), .ad_size(8), .depth(16), .wait_cycles(1)) u_w1 (
    .clk(clk), .rst(rst), .PSEL(psel[1]), .PEN(pen), .PW(pw), .PADDR(paddr),
    .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]),
    .PSLVERR(pslverr[1]), .xfer_cnt(cnt[1])
  );

  apb_slave_regfile #(.size(32), .ad_size(8), .depth(16), .wait_cycles(3)) u_w3 (
    .clk(clk), .rst(rst), .PSEL(psel[2]), .PEN(pen), .PW(pw), .PADDR(paddr),
    .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]),
    .PSLVERR(pslverr[2]), .xfer_cnt(cnt[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full APB transfer on DUT d, starting 1 time unit after a rising edge.
  // Master setup cycle S, FSM SETUP in S+1, PREADY expected in S+2+wt.
  // The latency check counts cycles from S+1 to the PREADY cycle: 1+wt.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input int wt, input string tag,
                      output logic [31:0] rd, output logic err);
    int n;
    bit done;
    psel[d] = 1'b1; pen = 1'b0; pw = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    pen  = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    check({tag, " latency"}, n, 1 + wt);
    rd  = prdata[d];
    err = pslverr[d];
    @(posedge clk); #1;
    psel[d] = 1'b0; pen = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    rst = 1'b1; psel = '0; pen = 1'b0; pw = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("por pready",  {31'd0, pready[1]},  32'd0);
    check("por prdata",  prdata[1],           32'd0);
    check("por pslverr", {31'd0, pslverr[1]}, 32'd0);
    check("por cnt",     {16'd0, cnt[1]},     32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Write/read with one wait state.
    xfer(1, 1'b1, 8'd2, 32'hDEADFACE, 1, "w1 wr2", rd, err);
    check("w1 wr2 err", {31'd0, err}, 32'd0);
    xfer(1, 1'b0, 8'd2, 32'h0, 1, "w1 rd2", rd, err);
    check("w1 rd2 data", rd, 32'hDEADFACE);
    check("w1 cnt", {16'd0, cnt[1]}, 32'd2);

    // Reset in the PREADY cycle of a read of address 2.
    psel[1] = 1'b1; pen = 1'b0; pw = 1'b0; paddr = 8'd2;
    @(posedge clk); #1; pen = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-rst pready", {31'd0, pready[1]}, 32'd1);
    check("pre-rst prdata", prdata[1], 32'hDEADFACE);
    #1 rst = 1'b1;
    #1;
    check("rst pready",  {31'd0, pready[1]},  32'd0);
    check("rst prdata",  prdata[1],           32'd0);
    check("rst pslverr", {31'd0, pslverr[1]}, 32'd0);
    check("rst cnt",     {16'd0, cnt[1]},     32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0; psel[1] = 1'b0; pen = 1'b0;
    @(posedge clk); #1;
    check("post-rst cnt", {16'd0, cnt[1]}, 32'd0);
    xfer(1, 1'b0, 8'd2, 32'h0, 1, "post-rst rd2", rd, err);
    check("post-rst rd2 data", rd, 32'h0);

    // Zero wait states, top valid address.
    xfer(0, 1'b1, 8'd15, 32'h12345678, 0, "w0 wr15", rd, err);
    xfer(0, 1'b0, 8'd15, 32'h0, 0, "w0 rd15", rd, err);
    check("w0 rd15 data", rd, 32'h12345678);
    check("w0 rd15 err", {31'd0, err}, 32'd0);

    // Out-of-range address 16; address 0 must keep its value.
    xfer(0, 1'b1, 8'd0, 32'h13579BDF, 0, "w0 wr0", rd, err);
    xfer(0, 1'b1, 8'd16, 32'hFFFFFFFF, 0, "w0 wr16", rd, err);
    check("w0 wr16 err", {31'd0, err}, 32'd1);
    xfer(0, 1'b0, 8'd16, 32'h0, 0, "w0 rd16", rd, err);
    check("w0 rd16 err", {31'd0, err}, 32'd1);
    check("w0 rd16 data", rd, 32'h0);
    xfer(0, 1'b0, 8'd0, 32'h0, 0, "w0 rd0", rd, err);
    check("w0 rd0 data", rd, 32'h13579BDF);
    check("w0 rd0 err", {31'd0, err}, 32'd0);
    check("w0 cnt", {16'd0, cnt[0]}, 32'd6);

    // Abort: PSEL dropped in the second access cycle, three wait states.
    psel[2] = 1'b1; pen = 1'b0; pw = 1'b1; paddr = 8'd4; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1; pen = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort acc1 pready", {31'd0, pready[2]}, 32'd0);
    @(posedge clk); #1; psel[2] = 1'b0;
    @(negedge clk);
    check("abort acc2 pready", {31'd0, pready[2]}, 32'd0);
    @(posedge clk); #1; pen = 1'b0;
    check("abort cnt", {16'd0, cnt[2]}, 32'd0);

    // Same write, reset pulsed in its access phase.
    psel[2] = 1'b1; pen = 1'b0; pw = 1'b1; paddr = 8'd4; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1; pen = 1'b1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("w3 rst pready", {31'd0, pready[2]}, 32'd0);
    @(negedge clk); rst = 1'b0; psel[2] = 1'b0; pen = 1'b0;
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'd4, 32'h0, 3, "w3 rd4", rd, err);
    check("w3 rd4 data", rd, 32'h0);
    check("w3 cnt", {16'd0, cnt[2]}, 32'd1);

    // Protocol violation: PSEL+PEN from IDLE without setup.
    psel[0] = 1'b1; pen = 1'b1; pw = 1'b1; paddr = 8'd3; pwdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("violation pready", {31'd0, pready[0]}, 32'd0);
    end
    @(posedge clk); #1; psel[0] = 1'b0; pen = 1'b0;
    check("violation cnt", {16'd0, cnt[0]}, 32'd0);
    xfer(0, 1'b0, 8'd3, 32'h0, 0, "w0 rd3", rd, err);
    check("w0 rd3 data", rd, 32'h0);
    check("w0 rd3 cnt", {16'd0, cnt[0]}, 32'd1);

    // Counter wrap: preload near the top, then complete two transfers.
    force u_w0.cnt = 16'hFFFE;
    #1 release u_w0.cnt;
    xfer(0, 1'b0, 8'd3, 32'h0, 0, "wrap rd a", rd, err);
    check("wrap cnt ffff", {16'd0, cnt[0]}, 32'h0000FFFF);
    xfer(0, 1'b0, 8'd3, 32'h0, 0, "wrap rd b", rd, err);
    check("wrap cnt 0000", {16'd0, cnt[0]}, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
